// File: rtl/qspi_ahb_slave_ctrl.sv
// AHB-side sequencing FSM for the QSPI slave: HREADY, capture strobes, buffer strobes, engine start/abort.
// Latency: XIP read = 1 request cycle + buffer wait + 1 data cycle; abort/timeout pulses are registered (one cycle after the decision).
// Backpressure: h_ready low while a flash read is outstanding or an indirect push is blocked by a full write buffer.
module qspi_ahb_slave_ctrl #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 5
) (
    input  logic       h_clk,
    input  logic       h_rstn,
    input  logic [2:0] h_burst,
    input  logic       non_seq_in,
    input  logic       seq_in,
    input  logic       idle_in,
    input  logic       busy_in,
    input  logic       enter_xip_mode_in,
    input  logic       enter_indrct_in,
    input  logic       indrct_wr_in,
    input  logic       tx_data_valid_in,
    input  logic       rd_buf_empty_in,
    input  logic       wr_buf_full_in,
    input  logic       indrct_done_in,
    output logic       h_ready,
    output logic       load_h_addr,
    output logic       load_h_burst,
    output logic       wr_rx_reg_out,
    output logic       rd_buf_rd_en,
    output logic       wr_buf_wr_en,
    output logic       xip_start_out,
    output logic       xip_abort_out,
    output logic       indrct_start_out,
    output logic       timeout_err
);

    localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0] HB_INCR = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_XIP_REQ,
        S_XIP_WAIT,
        S_XIP_DATA,
        S_XIP_BUSY,
        S_IND_START,
        S_IND_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         burst_q, burst_d;
    logic [CNT_W-1:0]   beats_q, beats_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               indrct_prev_q, indrct_prev_d;
    logic               push_pend_q, push_pend_d;
    logic               done_seen_q, done_seen_d;
    logic               xip_abort_q, xip_abort_d;
    logic               timeout_err_q, timeout_err_d;

    logic               push_want;
    logic               push_stall;

    function automatic logic [CNT_W-1:0] burst_beats(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: burst_beats = CNT_W'(4);
            3'd4, 3'd5: burst_beats = CNT_W'(8);
            3'd6, 3'd7: burst_beats = CNT_W'(16);
            default:    burst_beats = CNT_W'(1);
        endcase
    endfunction

    // A push is owed either from a fresh TX write or from one parked behind a full buffer.
    assign push_want  = push_pend_q | (indrct_wr_in & tx_data_valid_in);
    assign push_stall = push_want & wr_buf_full_in;

    assign xip_abort_out = xip_abort_q;
    assign timeout_err   = timeout_err_q;

    always_comb begin
        state_d          = state_q;
        burst_d          = burst_q;
        beats_d          = beats_q;
        timer_d          = '0;
        indrct_prev_d    = enter_indrct_in;
        push_pend_d      = push_pend_q;
        done_seen_d      = done_seen_q;
        xip_abort_d      = 1'b0;
        timeout_err_d    = 1'b0;
        h_ready          = 1'b1;
        load_h_addr      = 1'b0;
        load_h_burst     = 1'b0;
        wr_rx_reg_out    = 1'b0;
        rd_buf_rd_en     = 1'b0;
        wr_buf_wr_en     = 1'b0;
        xip_start_out    = 1'b0;
        indrct_start_out = 1'b0;

        case (state_q)
            S_IDLE: begin
                beats_d     = '0;
                push_pend_d = 1'b0;
                done_seen_d = 1'b0;
                if (enter_xip_mode_in) begin
                    load_h_addr  = 1'b1;
                    load_h_burst = 1'b1;
                    burst_d      = h_burst;
                    state_d      = S_XIP_REQ;
                end else if (enter_indrct_in && !indrct_prev_q) begin
                    state_d = S_IND_START;
                end
            end

            S_XIP_REQ: begin
                h_ready       = 1'b0;
                xip_start_out = 1'b1;
                beats_d       = burst_beats(burst_q);
                state_d       = S_XIP_WAIT;
            end

            S_XIP_WAIT: begin
                h_ready = 1'b0;
                if (!rd_buf_empty_in) begin
                    rd_buf_rd_en = 1'b1;
                    state_d      = S_XIP_DATA;
                end else if (timer_q == TMO_LAST) begin
                    xip_abort_d   = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            S_XIP_DATA: begin
                if (beats_q == CNT_W'(1)) begin
                    // Undefined-length INCR keeps streaming one beat at a time while SEQ continues.
                    if (burst_q == HB_INCR && seq_in) begin
                        state_d = S_XIP_WAIT;
                    end else begin
                        beats_d = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    beats_d = beats_q - CNT_W'(1);
                    if (seq_in) begin
                        state_d = S_XIP_WAIT;
                    end else if (busy_in) begin
                        state_d = S_XIP_BUSY;
                    end else begin
                        xip_abort_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end

            S_XIP_BUSY: begin
                if (idle_in || non_seq_in) begin
                    xip_abort_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (seq_in) begin
                    state_d = S_XIP_WAIT;
                end
            end

            S_IND_START: begin
                indrct_start_out = 1'b1;
                state_d          = S_IND_RUN;
            end

            S_IND_RUN: begin
                if (push_stall) begin
                    h_ready     = 1'b0;
                    push_pend_d = 1'b1;
                end else if (push_want) begin
                    wr_buf_wr_en = 1'b1;
                    push_pend_d  = 1'b0;
                end
                if (!indrct_wr_in && !rd_buf_empty_in) begin
                    rd_buf_rd_en  = 1'b1;
                    wr_rx_reg_out = 1'b1;
                end
                // Leaving with a push still parked would drop TX data, so remember done until it drains.
                if (indrct_done_in || done_seen_q) begin
                    if (push_stall) begin
                        done_seen_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge h_clk or negedge h_rstn) begin
        if (!h_rstn) begin
            state_q       <= S_IDLE;
            burst_q       <= '0;
            beats_q       <= '0;
            timer_q       <= '0;
            indrct_prev_q <= 1'b0;
            push_pend_q   <= 1'b0;
            done_seen_q   <= 1'b0;
            xip_abort_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            burst_q       <= burst_d;
            beats_q       <= beats_d;
            timer_q       <= timer_d;
            indrct_prev_q <= indrct_prev_d;
            push_pend_q   <= push_pend_d;
            done_seen_q   <= done_seen_d;
            xip_abort_q   <= xip_abort_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_qspi_ahb_slave_ctrl.sv
// Directed bench: transaction-level timeline model produces per-cycle expected outputs, plus literal count checks.
module tb_qspi_ahb_slave_ctrl;

    localparam int TMO = 1024;

    logic       h_clk = 1'b0;
    logic       h_rstn;
    logic [2:0] h_burst;
    logic       non_seq_in, seq_in, idle_in, busy_in;
    logic       enter_xip_mode_in, enter_indrct_in, indrct_wr_in;
    logic       tx_data_valid_in, rd_buf_empty_in, wr_buf_full_in, indrct_done_in;
    logic       h_ready, load_h_addr, load_h_burst, wr_rx_reg_out, rd_buf_rd_en;
    logic       wr_buf_wr_en, xip_start_out, xip_abort_out, indrct_start_out, timeout_err;

    qspi_ahb_slave_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(5)) dut (
        .h_clk(h_clk), .h_rstn(h_rstn), .h_burst(h_burst),
        .non_seq_in(non_seq_in), .seq_in(seq_in), .idle_in(idle_in), .busy_in(busy_in),
        .enter_xip_mode_in(enter_xip_mode_in), .enter_indrct_in(enter_indrct_in),
        .indrct_wr_in(indrct_wr_in), .tx_data_valid_in(tx_data_valid_in),
        .rd_buf_empty_in(rd_buf_empty_in), .wr_buf_full_in(wr_buf_full_in),
        .indrct_done_in(indrct_done_in), .h_ready(h_ready), .load_h_addr(load_h_addr),
        .load_h_burst(load_h_burst), .wr_rx_reg_out(wr_rx_reg_out), .rd_buf_rd_en(rd_buf_rd_en),
        .wr_buf_wr_en(wr_buf_wr_en), .xip_start_out(xip_start_out), .xip_abort_out(xip_abort_out),
        .indrct_start_out(indrct_start_out), .timeout_err(timeout_err)
    );

    always #5 h_clk = ~h_clk;

    // Expected output bits for the current cycle
    logic e_hr, e_ld, e_rx, e_pop, e_push, e_xs, e_xa, e_is, e_to;
    logic pend_abort, pend_tmo;
    string cur_tag;

    int errors = 0;
    int checks = 0;
    int c_pop = 0, c_push = 0, c_xa = 0, c_to = 0, c_xs = 0, c_is = 0, c_hl = 0, c_rx = 0;
    int b_pop, b_push, b_xa, b_to, b_xs, b_is, b_hl, b_rx;

    logic  lit_vld = 1'b0;
    string lit_name;
    int    lit_act, lit_exp;

    wire [9:0] dut_vec = {h_ready, load_h_addr, load_h_burst, wr_rx_reg_out, rd_buf_rd_en,
                          wr_buf_wr_en, xip_start_out, xip_abort_out, indrct_start_out, timeout_err};
    wire [9:0] exp_vec = {e_hr, e_ld, e_ld, e_rx, e_pop, e_push, e_xs, e_xa, e_is, e_to};

    // Single compare process: per-cycle output vector plus literal count requests
    always @(negedge h_clk) begin
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL %s t=%0t outputs got %b want %b (hr,ld_a,ld_b,rx,pop,push,xs,xa,is,to)",
                     cur_tag, $time, dut_vec, exp_vec);
        end
        if (h_ready === 1'b0) c_hl++;
        if (rd_buf_rd_en === 1'b1) c_pop++;
        if (wr_buf_wr_en === 1'b1) c_push++;
        if (xip_abort_out === 1'b1) c_xa++;
        if (timeout_err === 1'b1) c_to++;
        if (xip_start_out === 1'b1) c_xs++;
        if (indrct_start_out === 1'b1) c_is++;
        if (wr_rx_reg_out === 1'b1) c_rx++;
        if (lit_vld) begin
            checks++;
            if (lit_act != lit_exp) begin
                errors++;
                $display("FAIL %s got %0d want %0d", lit_name, lit_act, lit_exp);
            end
        end
    end

    task automatic nc();
        @(posedge h_clk);
        #1;
        h_burst = 3'd0; non_seq_in = 0; seq_in = 0; idle_in = 0; busy_in = 0;
        enter_xip_mode_in = 0; tx_data_valid_in = 0; rd_buf_empty_in = 1;
        wr_buf_full_in = 0; indrct_done_in = 0;
        e_hr = 1; e_ld = 0; e_rx = 0; e_pop = 0; e_push = 0; e_xs = 0; e_is = 0;
        e_xa = pend_abort; e_to = pend_tmo;
        pend_abort = 0; pend_tmo = 0;
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        lit_name = nm; lit_act = act; lit_exp = exp; lit_vld = 1'b1;
        @(negedge h_clk);
        #1;
        lit_vld = 1'b0;
    endtask

    task automatic snap();
        b_pop = c_pop; b_push = c_push; b_xa = c_xa; b_to = c_to;
        b_xs = c_xs; b_is = c_is; b_hl = c_hl; b_rx = c_rx;
    endtask

    function automatic int beats_of(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    // XIP read: lat empty cycles before each beat; master ends after n_stop beats;
    // n_busy BUSY cycles inserted after beat 1 when more beats follow.
    task automatic xip(input logic [2:0] burst, input int lat, input int n_stop, input int n_busy);
        int  n;
        bit  incr;
        incr = (burst == 3'd1);
        n = incr ? n_stop : beats_of(burst);
        if (!incr && n_stop < n) n = n_stop;
        nc(); enter_xip_mode_in = 1; non_seq_in = 1; h_burst = burst; e_ld = 1;
        nc(); e_hr = 0; e_xs = 1;
        for (int k = 1; k <= n; k++) begin
            repeat (lat) begin nc(); e_hr = 0; end
            nc(); e_hr = 0; rd_buf_empty_in = 0; e_pop = 1;
            nc();
            if (k == n) begin
                idle_in = 1;
                if (!incr && k < beats_of(burst)) pend_abort = 1;
            end else if (k == 1 && n_busy > 0) begin
                busy_in = 1;
                for (int j = 1; j <= n_busy; j++) begin
                    nc();
                    if (j < n_busy) busy_in = 1; else seq_in = 1;
                end
            end else begin
                seq_in = 1;
            end
        end
        nc();
    endtask

    // Indirect transfer: per-cycle vectors for tx pulses, buffer full, buffer empty; done pulse at done_at.
    task automatic ind(input bit wr, input logic [15:0] tx_v, input logic [15:0] full_v,
                       input logic [15:0] emp_v, input int done_at);
        int owed;
        bit dseen, exited;
        owed = 0; dseen = 0; exited = 0;
        indrct_wr_in = wr;
        nc(); enter_indrct_in = 1;
        nc(); e_is = 1;
        for (int c = 0; c < 16 && !exited; c++) begin
            nc();
            tx_data_valid_in = tx_v[c]; wr_buf_full_in = full_v[c];
            rd_buf_empty_in = emp_v[c]; indrct_done_in = (c == done_at);
            if (wr && tx_v[c]) owed++;
            if (!wr && !emp_v[c]) begin e_pop = 1; e_rx = 1; end
            if (owed > 0) begin
                if (full_v[c]) e_hr = 0;
                else begin e_push = 1; owed--; end
            end
            if (c == done_at) dseen = 1;
            if (dseen && owed == 0) exited = 1;
        end
        repeat (3) nc();
        enter_indrct_in = 0;
        nc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cur_tag = "reset";
        pend_abort = 0; pend_tmo = 0;
        h_rstn = 0; enter_indrct_in = 0; indrct_wr_in = 0;
        h_burst = 3'd0; non_seq_in = 0; seq_in = 0; idle_in = 0; busy_in = 0;
        enter_xip_mode_in = 0; tx_data_valid_in = 0; rd_buf_empty_in = 1;
        wr_buf_full_in = 0; indrct_done_in = 0;
        e_hr = 1; e_ld = 0; e_rx = 0; e_pop = 0; e_push = 0; e_xs = 0; e_xa = 0; e_is = 0; e_to = 0;
        nc(); nc();
        h_rstn = 1;
        nc(); nc();

        cur_tag = "xip_single"; snap();
        xip(3'd0, 2, 99, 0); nc();
        lit("single_xstart", c_xs - b_xs, 1);
        lit("single_hready_low", c_hl - b_hl, 4);
        lit("single_pops", c_pop - b_pop, 1);
        lit("single_abort", c_xa - b_xa, 0);

        cur_tag = "xip_incr4"; snap();
        xip(3'd3, 0, 99, 0); nc();
        lit("incr4_pops", c_pop - b_pop, 4);
        lit("incr4_abort", c_xa - b_xa, 0);
        lit("incr4_hready_low", c_hl - b_hl, 5);

        cur_tag = "xip_incr8_early_idle"; snap();
        xip(3'd5, 1, 3, 0); nc();
        lit("incr8_abort", c_xa - b_xa, 1);
        lit("incr8_pops", c_pop - b_pop, 3);

        cur_tag = "xip_wrap4_busy"; snap();
        xip(3'd2, 1, 99, 2); nc();
        lit("wrap4_pops", c_pop - b_pop, 4);
        lit("wrap4_abort", c_xa - b_xa, 0);

        cur_tag = "xip_incr_undef"; snap();
        xip(3'd1, 0, 3, 0); nc();
        lit("incr_pops", c_pop - b_pop, 3);
        lit("incr_abort", c_xa - b_xa, 0);

        cur_tag = "xip_timeout"; snap();
        nc(); enter_xip_mode_in = 1; non_seq_in = 1; e_ld = 1;
        nc(); e_hr = 0; e_xs = 1;
        repeat (TMO) begin nc(); e_hr = 0; end
        pend_abort = 1; pend_tmo = 1;
        nc(); nc();
        lit("tmo_err", c_to - b_to, 1);
        lit("tmo_abort", c_xa - b_xa, 1);
        lit("tmo_hready_low", c_hl - b_hl, 1 + TMO);
        lit("tmo_pops", c_pop - b_pop, 0);

        cur_tag = "ind_write"; snap();
        ind(1'b1, 16'h0112, 16'h0070, 16'hFFFF, 10);
        lit("indwr_pushes", c_push - b_push, 3);
        lit("indwr_start", c_is - b_is, 1);
        lit("indwr_hready_low", c_hl - b_hl, 3);

        cur_tag = "ind_write_done_push"; snap();
        ind(1'b1, 16'h0004, 16'h0000, 16'hFFFF, 2);
        lit("inddone_pushes", c_push - b_push, 1);

        cur_tag = "ind_read"; snap();
        ind(1'b0, 16'h0000, 16'h0000, 16'hFFD9, 6);
        lit("indrd_pops", c_pop - b_pop, 3);
        lit("indrd_rx", c_rx - b_rx, 3);
        lit("indrd_start", c_is - b_is, 1);

        cur_tag = "reset_in_wait"; snap();
        nc(); enter_xip_mode_in = 1; non_seq_in = 1; e_ld = 1;
        nc(); e_hr = 0; e_xs = 1;
        nc(); e_hr = 0;
        #2;
        h_rstn = 0; e_hr = 1;
        nc(); nc();
        h_rstn = 1;
        nc(); nc(); nc();
        lit("rst_abort", c_xa - b_xa, 0);
        lit("rst_tmo", c_to - b_to, 0);
        lit("rst_xstart", c_xs - b_xs, 1);
        lit("rst_pops", c_pop - b_pop, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
